// File: rtl/vga_timing.sv
// Purpose: 800x600 raster timing with registered, blank-gated RGB, sync pulses and a per-frame tick.
// Latency: the counters run free. rgb, blank, hsync, vsync and frame_tick lag the counters by one clock.
// Backpressure: none. The raster advances every pixel clock and the sink must accept every sample.
module vga_timing #(
   parameter int H_VISIBLE = 800,
   parameter int H_FP      = 56,
   parameter int H_SYNC    = 120,
   parameter int H_BP      = 64,
   parameter int V_VISIBLE = 600,
   parameter int V_FP      = 37,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 23,
   parameter bit SYNC_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  pixel_in,
   output logic [10:0] cntr_h,
   output logic [9:0]  cntr_v,
   output logic [5:0]  rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // Line and frame phases (active, front porch, sync, back porch) are
   // decoded directly from counter ranges, so no state register is kept.
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic h_wrap;
   logic v_wrap;
   logic visible;
   logic in_hs;
   logic in_vs;
   logic at_tick;

   // Decode the current raster position into wrap, visibility and sync-window flags.
   always_comb begin
      h_wrap  = (cntr_h == H_LAST);
      v_wrap  = (cntr_v == V_LAST);
      visible = (cntr_h < H_VIS_END) && (cntr_v < V_VIS_END);
      in_hs   = (cntr_h >= HS_START) && (cntr_h < HS_END);
      in_vs   = (cntr_v >= VS_START) && (cntr_v < VS_END);
      at_tick = (cntr_h == H_VIS_END) && (cntr_v == V_VIS_END);
   end

   // Horizontal counter runs every clock. The vertical counter steps on each horizontal wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cntr_h <= '0;
         cntr_v <= '0;
      end else if (h_wrap) begin
         cntr_h <= '0;
         cntr_v <= v_wrap ? '0 : cntr_v + 10'd1;
      end else begin
         cntr_h <= cntr_h + 11'd1;
      end
   end

   // Output stage registers the current position so that colour, blank and both syncs stay aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb        <= '0;
         blank      <= 1'b1;
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         frame_tick <= 1'b0;
      end else begin
         rgb        <= visible ? pixel_in : 6'd0;
         blank      <= ~visible;
         hsync      <= in_hs ? SYNC_POL : ~SYNC_POL;
         vsync      <= in_vs ? SYNC_POL : ~SYNC_POL;
         frame_tick <= at_tick;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Purpose: randomized self-checking bench for vga_timing, run on a scaled-down raster.
// Latency: the model predicts counters from cycles since reset and predicts outputs from the previous position.
// Backpressure: not applicable. A stimulus value is applied on every clock.
module tb_vga_timing;

   localparam int HV = 16, HF = 3, HS = 4, HB = 5;
   localparam int VV = 10, VF = 2, VS = 3, VB = 4;
   localparam int HT = HV + HF + HS + HB;   // 28
   localparam int VT = VV + VF + VS + VB;   // 19
   localparam int FT = HT * VT;             // 532

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  pixel_in = 6'd0;
   logic [10:0] cntr_h, n_cntr_h;
   logic [9:0]  cntr_v, n_cntr_v;
   logic [5:0]  rgb, n_rgb;
   logic        hsync, vsync, blank, frame_tick;
   logic        n_hsync, n_vsync, n_blank, n_frame_tick;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   longint cyc_since_rst = 0;
   int     exp_h = 0, exp_v = 0;
   logic [5:0] exp_rgb = 0;
   logic   exp_blank = 1, exp_hs = 0, exp_vs = 0, exp_ft = 0;

   vga_timing #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .cntr_h(cntr_h), .cntr_v(cntr_v),
      .rgb(rgb), .hsync(hsync), .vsync(vsync), .blank(blank), .frame_tick(frame_tick));

   vga_timing #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut_n (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .cntr_h(n_cntr_h), .cntr_v(n_cntr_v),
      .rgb(n_rgb), .hsync(n_hsync), .vsync(n_vsync), .blank(n_blank), .frame_tick(n_frame_tick));

   always #5 clk = ~clk;

   // Apply inputs, take one edge, advance the model, and settle 1 time unit past the edge.
   task automatic tick(input logic r, input logic [5:0] p);
      bit vis;
      rst = r;
      pixel_in = p;
      @(posedge clk);
      if (r) begin
         cyc_since_rst = 0;
         exp_rgb = 0; exp_blank = 1; exp_hs = 0; exp_vs = 0; exp_ft = 0;
      end else begin
         vis       = (exp_h < HV) && (exp_v < VV);
         exp_rgb   = vis ? p : 6'd0;
         exp_blank = !vis;
         exp_hs    = (exp_h >= HV + HF) && (exp_h < HV + HF + HS);
         exp_vs    = (exp_v >= VV + VF) && (exp_v < VV + VF + VS);
         exp_ft    = (exp_h == HV) && (exp_v == VV);
         cyc_since_rst++;
      end
      exp_h = int'(cyc_since_rst % HT);
      exp_v = int'((cyc_since_rst / HT) % VT);
      #1;
   endtask

   // Advance until the model reaches position (h,v). Returns 0 if the cycle budget runs out.
   task automatic run_to(input int h, input int v, output bit ok);
      ok = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         if (exp_h == h && exp_v == v) begin ok = 1; break; end
         tick(1'b0, 6'($urandom));
      end
   endtask

   task automatic test_reset();
      bit ok;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 6'h3f);
         n_cmp++;
         if (cntr_h !== 0 || cntr_v !== 0 || rgb !== 0 || blank !== 1 || hsync !== 0 ||
             vsync !== 0 || frame_tick !== 0 || n_hsync !== 1 || n_vsync !== 1) begin
            n_err++;
            $display("FAIL reset_init[%0d]: h=%0d v=%0d rgb=%0d blank=%b hs=%b vs=%b ft=%b nhs=%b nvs=%b, required 0 0 0 1 0 0 0 1 1",
                     i, cntr_h, cntr_v, rgb, blank, hsync, vsync, frame_tick, n_hsync, n_vsync);
         end
      end
      tick(1'b0, 6'h3f);
      n_cmp++;
      if (cntr_h !== 11'd1 || cntr_v !== 10'd0) begin
         n_err++; $display("FAIL reset_release: h=%0d v=%0d, required 1 0", cntr_h, cntr_v);
      end
      // Reset mid-line while hsync is asserted.
      run_to(HV + HF + 1, 2, ok);
      tick(1'b0, 6'h3f);
      n_cmp++;
      if (!ok || hsync !== 1'b1 || n_hsync !== 1'b0) begin
         n_err++; $display("FAIL pre_reset_hsync: ok=%0d hs=%b nhs=%b, required 1 1 0", ok, hsync, n_hsync);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 6'h3f);
         n_cmp++;
         if (cntr_h !== 0 || cntr_v !== 0 || rgb !== 0 || blank !== 1 || hsync !== 0 ||
             vsync !== 0 || frame_tick !== 0 || n_hsync !== 1) begin
            n_err++;
            $display("FAIL reset_mid[%0d]: h=%0d v=%0d rgb=%0d blank=%b hs=%b vs=%b ft=%b nhs=%b, required 0 0 0 1 0 0 0 1",
                     i, cntr_h, cntr_v, rgb, blank, hsync, vsync, frame_tick, n_hsync);
         end
      end
      tick(1'b0, 6'h00);
      n_cmp++;
      if (cntr_h !== 11'd1) begin
         n_err++; $display("FAIL reset_mid_release: h=%0d, required 1", cntr_h);
      end
   endtask

   task automatic test_line_wrap();
      bit ok;
      int cnt = 0;
      logic prev;
      run_to(HT - 1, 5, ok);
      tick(1'b0, 6'd0);
      n_cmp++;
      if (!ok || cntr_h !== 0 || cntr_v !== 10'd6) begin
         n_err++; $display("FAIL line_wrap: ok=%0d h=%0d v=%0d, required 0 6", ok, cntr_h, cntr_v);
      end
      prev = hsync;
      for (int i = 0; i < HT; i++) begin
         tick(1'b0, 6'($urandom));
         if (hsync === 1'b1) cnt++;
         if (hsync === 1'b1 && prev !== 1'b1) begin
            n_cmp++;
            if (cntr_h !== 11'(HV + HF + 1)) begin
               n_err++; $display("FAIL hsync_rise: at h=%0d, required %0d", cntr_h, HV + HF + 1);
            end
         end
         prev = hsync;
      end
      n_cmp++;
      if (cnt != HS) begin
         n_err++; $display("FAIL hsync_width: %0d clocks, required %0d", cnt, HS);
      end
   endtask

   task automatic test_frame_wrap();
      bit ok;
      int last = -1, pulses = 0, vs_cnt = 0;
      logic prev_ft = 0;
      run_to(HT - 1, VT - 1, ok);
      tick(1'b0, 6'd0);
      n_cmp++;
      if (!ok || cntr_h !== 0 || cntr_v !== 0) begin
         n_err++; $display("FAIL frame_wrap: ok=%0d h=%0d v=%0d, required 0 0", ok, cntr_h, cntr_v);
      end
      for (int c = 1; c <= 3 * FT + 10; c++) begin
         tick(1'b0, 6'($urandom));
         if (c <= FT && vsync === 1'b1) vs_cnt++;
         if (frame_tick === 1'b1) begin
            pulses++;
            n_cmp++;
            if (prev_ft === 1'b1 || cntr_h !== 11'(HV + 1) || cntr_v !== 10'(VV)) begin
               n_err++; $display("FAIL frame_tick_pos: prev=%b h=%0d v=%0d, required 0 %0d %0d",
                                 prev_ft, cntr_h, cntr_v, HV + 1, VV);
            end
            if (last >= 0) begin
               n_cmp++;
               if (c - last != FT) begin
                  n_err++; $display("FAIL frame_period: %0d clocks, required %0d", c - last, FT);
               end
            end
            last = c;
         end
         prev_ft = frame_tick;
      end
      n_cmp++;
      if (pulses != 3) begin
         n_err++; $display("FAIL frame_tick_count: %0d, required 3", pulses);
      end
      n_cmp++;
      if (vs_cnt != VS * HT) begin
         n_err++; $display("FAIL vsync_width: %0d clocks, required %0d", vs_cnt, VS * HT);
      end
   endtask

   task automatic test_blank_gating();
      bit ok;
      run_to(HV - 1, 3, ok);
      tick(1'b0, 6'h3f);
      n_cmp++;
      if (!ok || rgb !== 6'h3f || blank !== 1'b0) begin
         n_err++; $display("FAIL blank_last_visible: ok=%0d rgb=%0h blank=%b, required 3f 0", ok, rgb, blank);
      end
      tick(1'b0, 6'h3f);
      n_cmp++;
      if (rgb !== 6'h00 || blank !== 1'b1) begin
         n_err++; $display("FAIL blank_first_hblank: rgb=%0h blank=%b, required 0 1", rgb, blank);
      end
      run_to(0, VV, ok);
      tick(1'b0, 6'h3f);
      n_cmp++;
      if (!ok || rgb !== 6'h00 || blank !== 1'b1) begin
         n_err++; $display("FAIL blank_first_vblank: ok=%0d rgb=%0h blank=%b, required 0 1", ok, rgb, blank);
      end
   endtask

   task automatic test_pixel_alignment();
      bit ok;
      logic [5:0] drv;
      run_to(0, 1, ok);
      for (int i = 0; i < 2 * HT; i++) begin
         drv = cntr_h[5:0];
         tick(1'b0, drv);
         if (blank === 1'b0) begin
            n_cmp++;
            if (rgb !== drv || rgb !== exp_rgb) begin
               n_err++; $display("FAIL pixel_align: rgb=%0h, required %0h", rgb, drv);
            end
         end
      end
   endtask

   task automatic test_random();
      int shown = 0;
      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(0, 499) == 0), 6'($urandom));
         n_cmp++;
         if (cntr_h !== 11'(exp_h) || cntr_v !== 10'(exp_v) || rgb !== exp_rgb || blank !== exp_blank ||
             hsync !== exp_hs || vsync !== exp_vs || frame_tick !== exp_ft ||
             n_hsync !== !exp_hs || n_vsync !== !exp_vs) begin
            n_err++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random[%0d]: h=%0d v=%0d rgb=%0h bl=%b hs=%b vs=%b ft=%b nhs=%b nvs=%b, required %0d %0d %0h %b %b %b %b %b %b",
                        i, cntr_h, cntr_v, rgb, blank, hsync, vsync, frame_tick, n_hsync, n_vsync,
                        exp_h, exp_v, exp_rgb, exp_blank, exp_hs, exp_vs, exp_ft, !exp_hs, !exp_vs);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_wrap();
      test_frame_wrap();
      test_blank_gating();
      test_pixel_alignment();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
